// File: rtl/mem_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_if
// Description : Requester-side and memory-side signal bundle for the
//               round-robin memory request arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_req_arbiter_if #(
    parameter int WIDTH       = 16,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_REQ     = 4,
    parameter int GRANT_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_wr_rd;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [WIDTH-1:0]              req_rdata;
    logic                          req_err;
    logic                          mem_valid;
    logic                          mem_wr_rd;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [WIDTH-1:0]              mem_wdata;
    logic [WIDTH-1:0]              mem_rdata;
    logic                          mem_ready;
    logic                          busy;
    logic [GRANT_WIDTH-1:0]        grant_id;

    // Arbiter view
    modport master (
        input  req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, req_rdata, req_err, mem_valid, mem_wr_rd, mem_addr,
               mem_wdata, busy, grant_id
    );

    // Requester / memory environment view
    modport slave (
        output req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, req_rdata, req_err, mem_valid, mem_wr_rd, mem_addr,
               mem_wdata, busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Round-robin arbiter sharing one valid/ready memory port among
//               NUM_REQ requesters, with a watchdog on the memory handshake.
// Revision    : 1.0  initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 16
) (
    input  wire logic           clk,
    input  wire logic           res,
    mem_req_arbiter_if.master   bus
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_GW-1:0] c_LAST_ID = c_GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [c_GW-1:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic [c_CW-1:0]         r_cnt, w_cnt_nxt;
    logic [c_GW-1:0]         r_grant_id, w_grant_id_nxt;
    logic                    r_mem_valid, w_mem_valid_nxt;
    logic                    r_mem_wr_rd, w_mem_wr_rd_nxt;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [WIDTH-1:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic [NUM_REQ-1:0]      r_req_ready, w_req_ready_nxt;
    logic [WIDTH-1:0]        r_req_rdata, w_req_rdata_nxt;
    logic                    r_req_err, w_req_err_nxt;
    logic                    r_busy, w_busy_nxt;

    logic [c_GW-1:0]         w_cand [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   w_addr_arr [NUM_REQ];
    logic [WIDTH-1:0]        w_wdata_arr [NUM_REQ];
    logic                    w_found;
    logic [c_GW-1:0]         w_win;
    logic                    w_handshake;
    logic [NUM_REQ-1:0]      w_onehot;

    // Candidate order: rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ-1
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_cand[gi]      = c_GW'((int'(r_rr_ptr) + gi) % NUM_REQ);
            assign w_addr_arr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req_valid[w_cand[i]]) begin
                w_found = 1'b1;
                w_win   = w_cand[i];
            end
        end
    end

    assign w_handshake = r_mem_valid && bus.mem_ready;
    assign w_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_grant_id  <= '0;
            r_mem_valid <= 1'b0;
            r_mem_wr_rd <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_req_ready <= '0;
            r_req_rdata <= '0;
            r_req_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_wr_rd <= w_mem_wr_rd_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_req_rdata <= w_req_rdata_nxt;
            r_req_err   <= w_req_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_cnt_nxt       = r_cnt;
        w_grant_id_nxt  = r_grant_id;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_wr_rd_nxt = r_mem_wr_rd;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_req_ready_nxt = '0;
        w_req_rdata_nxt = r_req_rdata;
        w_req_err_nxt   = 1'b0;
        w_busy_nxt      = r_busy;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_grant_id_nxt  = w_win;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_wr_rd_nxt = bus.req_wr_rd[w_win];
                    w_mem_addr_nxt  = w_addr_arr[w_win];
                    w_mem_wdata_nxt = w_wdata_arr[w_win];
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_MEM;
                end
            end
            S_MEM: begin
                if (w_handshake) begin
                    w_req_rdata_nxt = r_mem_wr_rd ? '0 : bus.mem_rdata;
                    w_req_ready_nxt = w_onehot;
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = S_DONE;
                end else if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
                    // Watchdog abort: complete the requester with an error
                    w_req_rdata_nxt = '0;
                    w_req_err_nxt   = 1'b1;
                    w_req_ready_nxt = w_onehot;
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_rr_ptr_nxt = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;
                w_cnt_nxt    = '0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = r_req_ready;
    assign bus.req_rdata = r_req_rdata;
    assign bus.req_err   = r_req_err;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_wr_rd = r_mem_wr_rd;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Directed, table-driven self-checking bench for mem_req_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic clk;
    logic res;

    mem_req_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_REQ(NREQ)) bus ();

    mem_req_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_REQ(NREQ), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  wr;
        logic [5:0]  abase;
        logic [15:0] dbase;
        logic [15:0] rdata;
        int          stall;
        logic [1:0]  g;
        logic [5:0]  ea;
        logic [15:0] ed;
        logic        ew;
        logic [15:0] er;
        logic        ee;
        int          ncyc;
    } vec_t;

    vec_t vecs [11];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Requester i presents addr = abase+i and wdata = dbase+i
    task automatic set_req(input logic [3:0] valid, input logic [3:0] wr,
                           input logic [5:0] abase, input logic [15:0] dbase);
        bus.req_valid = valid;
        bus.req_wr_rd = wr;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]       = abase + 6'(i);
            bus.req_wdata[i*WIDTH +: WIDTH] = dbase + 16'(i);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int  nv;
        bit  done;
        bit  bad;
        logic [3:0] exp_oh;
        string tag;
        tag    = $sformatf("v%0d", k);
        exp_oh = 4'b0001 << v.g;
        @(negedge clk);
        set_req(v.valid, v.wr, v.abase, v.dbase);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = v.rdata;
        @(negedge clk);
        chk({tag, " grant_id"},  32'(bus.grant_id),  32'(v.g));
        chk({tag, " mem_valid"}, 32'(bus.mem_valid), 32'd1);
        chk({tag, " busy"},      32'(bus.busy),      32'd1);
        chk({tag, " mem_addr"},  32'(bus.mem_addr),  32'(v.ea));
        chk({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(v.ed));
        chk({tag, " mem_wr_rd"}, 32'(bus.mem_wr_rd), 32'(v.ew));
        nv = 0; done = 1'b0; bad = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.mem_valid) begin
                nv++;
                if (bus.mem_addr !== v.ea || bus.mem_wdata !== v.ed || bus.mem_wr_rd !== v.ew)
                    bad = 1'b1;
            end
            bus.mem_ready = (c == v.stall);
            @(negedge clk);
            if (bus.req_ready != 4'b0000) done = 1'b1;
        end
        chk({tag, " ack_seen"},       32'(done),          32'd1);
        chk({tag, " req_ready"},      32'(bus.req_ready), 32'(exp_oh));
        chk({tag, " req_rdata"},      32'(bus.req_rdata), 32'(v.er));
        chk({tag, " req_err"},        32'(bus.req_err),   32'(v.ee));
        chk({tag, " mem_valid_low"},  32'(bus.mem_valid), 32'd0);
        chk({tag, " valid_cycles"},   32'(nv),            32'(v.ncyc));
        chk({tag, " fields_stable"},  32'(bad),           32'd0);
        bus.mem_ready = 1'b0;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk({tag, " ready_cleared"},  32'(bus.req_ready), 32'd0);
        chk({tag, " err_cleared"},    32'(bus.req_err),   32'd0);
        chk({tag, " idle_busy"},      32'(bus.busy),      32'd0);
    endtask

    initial begin
        //           valid    wr       abase  dbase     rdata     stl g     ea     ed        ew    er        ee    ncyc
        vecs[0]  = '{4'b1111, 4'b0101, 6'h10, 16'h2000, 16'hC0DE, 0,  2'd0, 6'h10, 16'h2000, 1'b1, 16'h0000, 1'b0, 1};
        vecs[1]  = '{4'b1111, 4'b0101, 6'h10, 16'h2000, 16'h1111, 0,  2'd1, 6'h11, 16'h2001, 1'b0, 16'h1111, 1'b0, 1};
        vecs[2]  = '{4'b1111, 4'b0101, 6'h10, 16'h2000, 16'h2222, 1,  2'd2, 6'h12, 16'h2002, 1'b1, 16'h0000, 1'b0, 2};
        vecs[3]  = '{4'b1111, 4'b0101, 6'h10, 16'h2000, 16'h3333, 0,  2'd3, 6'h13, 16'h2003, 1'b0, 16'h3333, 1'b0, 1};
        vecs[4]  = '{4'b1111, 4'b0101, 6'h08, 16'h7000, 16'h4444, 0,  2'd0, 6'h08, 16'h7000, 1'b1, 16'h0000, 1'b0, 1};
        vecs[5]  = '{4'b0100, 4'b0000, 6'h03, 16'hA000, 16'hBEEF, 0,  2'd2, 6'h05, 16'hA002, 1'b0, 16'hBEEF, 1'b0, 1};
        vecs[6]  = '{4'b1010, 4'b0000, 6'h30, 16'h0000, 16'hAAAA, 1,  2'd3, 6'h33, 16'h0003, 1'b0, 16'hAAAA, 1'b0, 2};
        vecs[7]  = '{4'b1010, 4'b0000, 6'h3E, 16'h0000, 16'h5A5A, 0,  2'd1, 6'h3F, 16'h0001, 1'b0, 16'h5A5A, 1'b0, 1};
        vecs[8]  = '{4'b0001, 4'b0001, 6'h3F, 16'h1234, 16'h5555, 3,  2'd0, 6'h3F, 16'h1234, 1'b1, 16'h0000, 1'b0, 4};
        vecs[9]  = '{4'b1000, 4'b0000, 6'h00, 16'h0000, 16'hDEAD, 99, 2'd3, 6'h03, 16'h0003, 1'b0, 16'h0000, 1'b1, TIMEOUT};
        vecs[10] = '{4'b0010, 4'b0000, 6'h20, 16'h0100, 16'h0F0F, 2,  2'd1, 6'h21, 16'h0101, 1'b0, 16'h0F0F, 1'b0, 3};

        res = 1'b0;
        set_req(4'b0000, 4'b0000, 6'h00, 16'h0000);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst req_rdata", 32'(bus.req_rdata), 32'd0);
        chk("rst req_err",   32'(bus.req_err),   32'd0);
        chk("rst mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst mem_bus",   32'({bus.mem_wr_rd, bus.mem_addr, bus.mem_wdata}), 32'd0);
        chk("rst busy",      32'(bus.busy),      32'd0);
        chk("rst grant_id",  32'(bus.grant_id),  32'd0);
        res = 1'b1;

        // Stray mem_ready with nothing outstanding
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle mem_ready req_ready", 32'(bus.req_ready), 32'd0);
        chk("idle mem_ready busy",      32'(bus.busy),      32'd0);
        bus.mem_ready = 1'b0;

        for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

        // Reset in the middle of a memory transaction
        @(negedge clk);
        set_req(4'b0100, 4'b0000, 6'h10, 16'h9000);
        @(negedge clk);
        chk("pre-rst mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("pre-rst grant_id",  32'(bus.grant_id),  32'd2);
        res = 1'b0;
        set_req(4'b0110, 4'b0000, 6'h10, 16'h9000);
        #1;
        chk("async rst mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("async rst busy",      32'(bus.busy),      32'd0);
        chk("async rst grant_id",  32'(bus.grant_id),  32'd0);
        chk("async rst mem_addr",  32'(bus.mem_addr),  32'd0);
        @(negedge clk);
        chk("in rst req_ready", 32'(bus.req_ready), 32'd0);
        res = 1'b1;
        @(negedge clk);
        chk("post-rst grant_id",  32'(bus.grant_id),  32'd1);
        chk("post-rst mem_valid", 32'(bus.mem_valid), 32'd1);
        chk("post-rst mem_addr",  32'(bus.mem_addr),  32'h11);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h7777;
        @(negedge clk);
        chk("post-rst req_ready", 32'(bus.req_ready), 32'b0010);
        chk("post-rst req_rdata", 32'(bus.req_rdata), 32'h7777);
        chk("post-rst req_err",   32'(bus.req_err),   32'd0);
        bus.mem_ready = 1'b0;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("post-rst idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter that shares one memory bus (valid/ready, wr_rd, addr, wdata, rdata) between NUM_REQ requesters.
- Latches the winning request and drives it on the memory side until the memory accepts it, or until a watchdog timeout expires.
- Returns the read data and a one-cycle acknowledge to the winning requester.
- Sits between the bench/driver-side masters and the memory block, in the memory clock domain.

Parameters:
- WIDTH, 16, data width in bits
- DEPTH, 64, memory depth in words
- ADDR_WIDTH, $clog2(DEPTH) (=6), address width
- NUM_REQ, 4, number of requesters (>=2)
- TIMEOUT, 16, max MEM-state cycles waiting for mem_ready; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on posedge
- res  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request
- req_wr_rd  in  NUM_REQ  per-requester direction (1=write, 0=read)
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*WIDTH  packed write data, same packing
- req_ready  out  NUM_REQ  one-hot completion pulse
- req_rdata  out  WIDTH  read data; valid with the req_ready pulse
- req_err  out  1  timeout flag; valid with the req_ready pulse
- mem_valid  out  1  memory request valid
- mem_wr_rd  out  1  memory direction
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data; sampled on the handshake cycle
- mem_ready  in  1  memory accept
- busy  out  1  state != IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs 0: req_ready, req_rdata, req_err, mem_*, busy, grant_id.
  - Reset mid-transaction discards the transaction with no ack and no error.
- All outputs are registered.
- FSM states:
  - IDLE:
    - Any req_valid: pick the first set bit searching from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
    - Latch that requester's wr_rd/addr/wdata into mem_*; set grant_id=winner, mem_valid=1, busy=1; go to MEM.
    - No req_valid: stay in IDLE.
  - MEM:
    - mem_valid=1; mem_wr_rd/addr/wdata held stable.
    - mem_valid && mem_ready:
      - For a read, capture mem_rdata into req_rdata; for a write, req_rdata=0.
      - req_err=0; mem_valid=0; go to DONE.
    - mem_ready=0: counter increments.
    - TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready=0: abort. mem_valid=0, req_err=1, req_rdata=0; go to DONE.
  - DONE (exactly one cycle):
    - req_ready[grant_id]=1 together with req_rdata/req_err.
    - rr_ptr = (grant_id+1) mod NUM_REQ.
    - Go to IDLE. req_ready, req_err and counter clear on the next cycle.
- Requester contract:
  - Hold req_valid and fields stable until the req_ready pulse.
  - Drop req_valid, or present a new request, in the cycle after the pulse.
  - DONE->IDLE spacing guarantees a stale req_valid is never re-granted.
- Latency, minimum:
  - req_valid seen in IDLE at cycle N -> mem_valid at N+1.
  - mem_ready at N+1 -> req_ready at N+2 -> IDLE at N+3, eligible to grant again.
- Timeout: mem_valid is high for exactly TIMEOUT cycles before the abort.
- Fairness: a continuously requesting master waits at most NUM_REQ-1 grants.
- Field changes:
  - req_valid withdrawn while in MEM/DONE: the transaction still completes and the pulse still fires.
  - Changes to non-granted requesters' fields have no effect.
- mem_ready while mem_valid=0 is ignored.

Test Plan:
- Single read: req_valid[2]=1, wr_rd=0, addr=6'h05; mem_ready=1 on the first mem_valid cycle with mem_rdata=16'hBEEF -> mem_valid 1 cycle, req_ready=4'b0100 exactly 2 cycles after grant, req_rdata=16'hBEEF, req_err=0.
- Write with backpressure: req 0 write addr=6'h3F, wdata=16'h1234; mem_ready low 3 cycles -> mem_addr/mem_wdata stable 4 cycles, req_ready=4'b0001 once, rdata=0.
- Round-robin: all 4 req_valid held high, re-asserted after each ack -> grant_id sequence 0,1,2,3,0; no requester granted twice before others.
- Wrap/skip: rr_ptr=3 with requests on 1 and 3 -> grant 3 then 1.
- Timeout: TIMEOUT=16, mem_ready tied 0 -> mem_valid high exactly 16 cycles, req_ready pulse with req_err=1, req_rdata=0; next request is then served normally.
- Reset mid-MEM: res=0 for 1 cycle while mem_valid=1 -> all outputs 0 immediately, no req_ready pulse; after release, a pending req_valid[1] is granted with grant_id=1.
